// File: rtl/ifetch_if.sv
// Fetch-stage bus bundle: imem request/response, redirect input and the decode handshake.
// The master side is the fetch stage. The slave side is the imem/decode/back-end environment.
interface ifetch_if #(
    parameter int unsigned PC_W = 10
);
    logic            fetch_en;
    logic [PC_W-1:0] imem_addr;
    logic [1:0]      imem_word;
    logic [63:0]     imem_data;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_inst;
    logic [PC_W-1:0] id_pc;

    modport master (
        input  fetch_en, imem_data, redirect_valid, redirect_pc, id_ready,
        output imem_addr, imem_word, id_valid, id_inst, id_pc
    );

    modport slave (
        output fetch_en, imem_data, redirect_valid, redirect_pc, id_ready,
        input  imem_addr, imem_word, id_valid, id_inst, id_pc
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, drives imem and buffers {pc, inst} pairs in a 2-entry
// queue for decode. A redirect flushes the queue and restarts fetch at the new target.
module ifetch #(
    parameter int unsigned     PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
    input  logic     clk,
    input  logic     rst_n,
    ifetch_if.master bus
);
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned INST_W = 32;

    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_ent_pc   [DEPTH];
    logic [INST_W-1:0] r_ent_inst [DEPTH];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_valid;
    logic w_pop;
    logic w_push;

    assign w_valid = (r_count != CNT_W'(0));
    assign w_pop   = w_valid & bus.id_ready;
    // A full queue can still accept a push when the head leaves in the same cycle.
    assign w_push  = bus.fetch_en & ~bus.redirect_valid
                   & ((r_count != CNT_W'(DEPTH)) | w_pop);

    // Outputs come only from state; imem_data and id_ready never reach id_* combinationally.
    assign bus.imem_addr = r_pc;
    assign bus.imem_word = 2'b10;
    assign bus.id_valid  = w_valid;
    assign bus.id_inst   = w_valid ? r_ent_inst[r_rd_ptr] : NOP_INST;
    assign bus.id_pc     = w_valid ? r_ent_pc[r_rd_ptr]   : PC_W'(0);

    // PC, queue storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= CNT_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                r_ent_pc[i]   <= PC_W'(0);
                r_ent_inst[i] <= INST_W'(0);
            end
        end else if (bus.redirect_valid) begin
            r_pc     <= {bus.redirect_pc[PC_W-1:2], 2'b00};
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= CNT_W'(0);
        end else begin
            if (w_push) begin
                r_ent_pc[r_wr_ptr]   <= r_pc;
                r_ent_inst[r_wr_ptr] <= bus.imem_data[INST_W-1:0];
                r_pc                 <= r_pc + PC_W'(4);
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios plus a randomized run scored
// against a queue-based reference model of the fetch stage.
module tb_ifetch;
    localparam int unsigned PC_W = 10;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     inst;
    } ent_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic [31:0]     mem [256];
    ent_t            mq [$];
    logic [PC_W-1:0] mpc;

    ifetch_if #(.PC_W(PC_W)) bus ();

    ifetch #(.PC_W(PC_W), .RESET_PC(10'h000), .NOP_INST(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Upper half carries the inverse word so only bits [31:0] may be captured.
    assign bus.imem_data = {~mem[bus.imem_addr[9:2]], mem[bus.imem_addr[9:2]]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        mpc = 10'h000;
    endtask

    // One clock: drive inputs at the negedge, advance the model at the posedge, return at the next negedge.
    task automatic step(input logic fe, input logic rv, input logic [PC_W-1:0] rpc, input logic rdy);
        logic pop, push;
        int   n;
        ent_t e;
        bus.fetch_en       = fe;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.id_ready       = rdy;
        @(posedge clk);
        n    = mq.size();
        pop  = (n != 0) && rdy;
        push = fe && !rv && ((n < 2) || pop);
        if (rv) begin
            mq.delete();
            mpc = {rpc[9:2], 2'b00};
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.pc   = mpc;
                e.inst = mem[mpc[9:2]];
                mq.push_back(e);
                mpc = mpc + 10'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.fetch_en = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        n_checks++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.id_valid); end
        n_checks++; if (bus.id_inst !== NOP) begin n_fail++; $display("FAIL reset_inst got=%h exp=%h", bus.id_inst, NOP); end
        n_checks++; if (bus.id_pc !== 10'h000) begin n_fail++; $display("FAIL reset_pc got=%h exp=000", bus.id_pc); end
        n_checks++; if (bus.imem_addr !== 10'h000) begin n_fail++; $display("FAIL reset_addr got=%h exp=000", bus.imem_addr); end
        n_checks++; if (bus.imem_word !== 2'b10) begin n_fail++; $display("FAIL reset_word got=%b exp=10", bus.imem_word); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_stream();
        logic [PC_W-1:0] ep [3];
        logic [31:0]     ei [3];
        ep = '{10'h000, 10'h004, 10'h008};
        ei = '{32'h000002b7, 32'h00a28293, 32'h00a00393};
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, '0, 1'b1);
            n_checks++; if (bus.id_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got=%b exp=1", k, bus.id_valid); end
            n_checks++; if (bus.id_pc !== ep[k]) begin n_fail++; $display("FAIL stream_pc[%0d] got=%h exp=%h", k, bus.id_pc, ep[k]); end
            n_checks++; if (bus.id_inst !== ei[k]) begin n_fail++; $display("FAIL stream_inst[%0d] got=%h exp=%h", k, bus.id_inst, ei[k]); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            n_checks++; if (bus.id_inst !== 32'h000002b7 || bus.id_pc !== 10'h000) begin
                n_fail++; $display("FAIL stall_hold[%0d] got=%h/%h exp=000002b7/000", k, bus.id_inst, bus.id_pc);
            end
        end
        n_checks++; if (bus.imem_addr !== 10'h008) begin n_fail++; $display("FAIL stall_pc got=%h exp=008", bus.imem_addr); end
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b0, '0, 1'b1);
            n_checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 10'(4 * k)) begin
                n_fail++; $display("FAIL drain_pc[%0d] got=%h v=%b exp=%h", k, bus.id_pc, bus.id_valid, 10'(4 * k));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 10'h046, 1'b1);
        n_checks++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_bubble got=%b exp=0", bus.id_valid); end
        n_checks++; if (bus.imem_addr !== 10'h044) begin n_fail++; $display("FAIL redir_addr got=%h exp=044", bus.imem_addr); end
        step(1'b1, 1'b0, '0, 1'b0);
        n_checks++; if (bus.id_valid !== 1'b1) begin n_fail++; $display("FAIL redir_valid got=%b exp=1", bus.id_valid); end
        n_checks++; if (bus.id_pc !== 10'h044) begin n_fail++; $display("FAIL redir_pc got=%h exp=044", bus.id_pc); end
        n_checks++; if (bus.id_inst !== mem[17]) begin n_fail++; $display("FAIL redir_inst got=%h exp=%h", bus.id_inst, mem[17]); end
    endtask

    task automatic test_wrap();
        step(1'b1, 1'b1, 10'h3F8, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        n_checks++; if (bus.id_pc !== 10'h3F8) begin n_fail++; $display("FAIL wrap_pre got=%h exp=3f8", bus.id_pc); end
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        n_checks++; if (bus.id_pc !== 10'h000 || bus.id_valid !== 1'b1) begin
            n_fail++; $display("FAIL wrap_pc got=%h v=%b exp=000", bus.id_pc, bus.id_valid);
        end
        n_checks++; if (bus.id_inst !== mem[0]) begin n_fail++; $display("FAIL wrap_inst got=%h exp=%h", bus.id_inst, mem[0]); end
        n_checks++; if ((^{bus.id_inst, bus.id_pc, bus.id_valid, bus.imem_addr}) === 1'bx) begin
            n_fail++; $display("FAIL wrap_x got=%h/%h/%h", bus.id_inst, bus.id_pc, bus.imem_addr);
        end
    endtask

    task automatic test_fetch_off();
        do_reset();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        n_checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 10'h004) begin
            n_fail++; $display("FAIL off_pop1 got=%h v=%b exp=004", bus.id_pc, bus.id_valid);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            n_checks++; if (bus.id_valid !== 1'b0 || bus.id_inst !== NOP || bus.id_pc !== 10'h000) begin
                n_fail++; $display("FAIL off_empty[%0d] got=%b/%h/%h exp=0/%h/000", k, bus.id_valid, bus.id_inst, bus.id_pc, NOP);
            end
            n_checks++; if (bus.imem_addr !== 10'h008) begin n_fail++; $display("FAIL off_addr[%0d] got=%h exp=008", k, bus.imem_addr); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, '0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid got=%b exp=0", bus.id_valid); end
        n_checks++; if (bus.imem_addr !== 10'h000) begin n_fail++; $display("FAIL areset_addr got=%h exp=000", bus.imem_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 1'b0, '0, 1'b1);
        n_checks++; if (bus.id_pc !== 10'h000 || bus.id_inst !== 32'h000002b7) begin
            n_fail++; $display("FAIL areset_refetch got=%h/%h exp=000/000002b7", bus.id_pc, bus.id_inst);
        end
    endtask

    task automatic test_random();
        logic [31:0]     ei;
        logic [PC_W-1:0] ep;
        logic            ev;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            step(($urandom % 8) != 0, ($urandom % 16) == 0, 10'($urandom), ($urandom % 4) != 0);
            ev = (mq.size() != 0);
            ei = ev ? mq[0].inst : NOP;
            ep = ev ? mq[0].pc : 10'h000;
            n_checks++; if (bus.id_valid !== ev || bus.id_inst !== ei || bus.id_pc !== ep) begin
                n_fail++; $display("FAIL rand_head[%0d] got=%b/%h/%h exp=%b/%h/%h", k, bus.id_valid, bus.id_inst, bus.id_pc, ev, ei, ep);
            end
            n_checks++; if (bus.imem_addr !== mpc) begin n_fail++; $display("FAIL rand_addr[%0d] got=%h exp=%h", k, bus.imem_addr, mpc); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h000002b7;
        mem[1] = 32'h00a28293;
        mem[2] = 32'h00a00393;
        rst_n = 1'b0;
        bus.fetch_en = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_fetch_off();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
